// File: rtl/collision_scheduler.sv
// Per-frame pair scheduler: walks all unordered ball pairs, issues eligible ones to a
// shared collision unit over req/ack, and latches the first hit per ball.
module collision_scheduler #(
  parameter int unsigned NUM_BALLS = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          startOfFrame,
  input  logic [NUM_BALLS-1:0]          ball_active,
  output logic                          calc_req,
  output logic [3:0]                    calc_idx_a,
  output logic [3:0]                    calc_idx_b,
  input  logic                          calc_ack,
  input  logic                          calc_hit,
  input  logic signed [31:0]            calc_vx_a,
  input  logic signed [31:0]            calc_vy_a,
  input  logic signed [31:0]            calc_vx_b,
  input  logic signed [31:0]            calc_vy_b,
  output logic [NUM_BALLS-1:0]          collision,
  output logic signed [NUM_BALLS*32-1:0] nxt_vx,
  output logic signed [NUM_BALLS*32-1:0] nxt_vy,
  output logic                          busy,
  output logic                          done,
  output logic                          overrun
);

  typedef enum logic [1:0] {IDLE, NEXT, REQ, DONE} state_t;

  localparam logic [3:0] LAST_A = 4'(NUM_BALLS - 2);
  localparam logic [3:0] LAST_B = 4'(NUM_BALLS - 1);

  state_t                     state_q, state_d;
  logic [3:0]                 pa_q, pa_d;
  logic [3:0]                 pb_q, pb_d;
  logic [NUM_BALLS-1:0]       coll_q, coll_d;
  logic [NUM_BALLS*32-1:0]    vx_q, vx_d;
  logic [NUM_BALLS*32-1:0]    vy_q, vy_d;
  logic                       ovr_q, ovr_d;

  logic [15:0] active_ext;
  logic [15:0] coll_ext;
  logic        eligible;
  logic        last_pair;
  logic        take;
  logic        advance;

  // Widened copies let the 4-bit pair indices select bits for any legal ball count
  assign active_ext = 16'(ball_active);
  assign coll_ext   = 16'(coll_q);
  assign eligible   = active_ext[pa_q] & active_ext[pb_q] & ~coll_ext[pa_q] & ~coll_ext[pb_q];
  assign last_pair  = (pa_q == LAST_A) && (pb_q == LAST_B);
  assign take       = (state_q == REQ) && calc_ack;
  assign advance    = ((state_q == NEXT) && !eligible) || take;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (startOfFrame) state_d = NEXT;
      NEXT: begin
        if (eligible)       state_d = REQ;
        else if (last_pair) state_d = DONE;
      end
      REQ:  if (calc_ack) state_d = last_pair ? DONE : NEXT;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    pa_d   = pa_q;
    pb_d   = pb_q;
    coll_d = coll_q;
    vx_d   = vx_q;
    vy_d   = vy_q;
    ovr_d  = ovr_q | (startOfFrame && (state_q != IDLE));

    if ((state_q == IDLE) && startOfFrame) begin
      coll_d = '0;
      vx_d   = '0;
      vy_d   = '0;
      pa_d   = 4'd0;
      pb_d   = 4'd1;
    end

    if (take && calc_hit) begin
      for (int unsigned i = 0; i < NUM_BALLS; i++) begin
        if (pa_q == 4'(i)) begin
          coll_d[i]          = 1'b1;
          vx_d[i*32 +: 32]   = calc_vx_a;
          vy_d[i*32 +: 32]   = calc_vy_a;
        end
        if (pb_q == 4'(i)) begin
          coll_d[i]          = 1'b1;
          vx_d[i*32 +: 32]   = calc_vx_b;
          vy_d[i*32 +: 32]   = calc_vy_b;
        end
      end
    end

    // Wrap back to (0,1) after the last pair so the idle pair matches the reset pair
    if (advance) begin
      if (last_pair) begin
        pa_d = 4'd0;
        pb_d = 4'd1;
      end else if (pb_q == LAST_B) begin
        pa_d = pa_q + 4'd1;
        pb_d = pa_q + 4'd2;
      end else begin
        pb_d = pb_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pa_q   <= 4'd0;
      pb_q   <= 4'd1;
      coll_q <= '0;
      vx_q   <= '0;
      vy_q   <= '0;
      ovr_q  <= 1'b0;
    end else begin
      pa_q   <= pa_d;
      pb_q   <= pb_d;
      coll_q <= coll_d;
      vx_q   <= vx_d;
      vy_q   <= vy_d;
      ovr_q  <= ovr_d;
    end
  end

  always_comb begin
    calc_req   = (state_q == REQ);
    busy       = (state_q == NEXT) || (state_q == REQ);
    done       = (state_q == DONE);
    calc_idx_a = pa_q;
    calc_idx_b = pb_q;
    collision  = coll_q;
    nxt_vx     = vx_q;
    nxt_vy     = vy_q;
    overrun    = ovr_q;
  end

endmodule

// File: tb/tb_collision_scheduler.sv
// Scoreboard bench for collision_scheduler: expected pairs and scan results are queued
// by the stimulus and checked by an independent monitor.
module tb_collision_scheduler;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              sof = 1'b0;
  logic [N-1:0]      act = '1;
  logic              calc_req;
  logic [3:0]        calc_idx_a, calc_idx_b;
  logic              calc_ack = 1'b0;
  logic              calc_hit = 1'b0;
  logic [31:0]       vxa = '0, vya = '0, vxb = '0, vyb = '0;
  logic [N-1:0]      collision;
  logic [N*32-1:0]   nxt_vx, nxt_vy;
  logic              busy, done, overrun;

  collision_scheduler #(.NUM_BALLS(N)) dut (
    .clk(clk), .reset(reset), .startOfFrame(sof), .ball_active(act),
    .calc_req(calc_req), .calc_idx_a(calc_idx_a), .calc_idx_b(calc_idx_b),
    .calc_ack(calc_ack), .calc_hit(calc_hit),
    .calc_vx_a(vxa), .calc_vy_a(vya), .calc_vx_b(vxb), .calc_vy_b(vyb),
    .collision(collision), .nxt_vx(nxt_vx), .nxt_vy(nxt_vy),
    .busy(busy), .done(done), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct { int a; int b; int lat; } pair_t;
  typedef struct {
    int per; logic [N-1:0] coll; logic [N*32-1:0] vx; logic [N*32-1:0] vy; logic ovr;
  } done_t;

  pair_t pq[$];
  done_t dq[$];
  done_t md;
  int checks = 0, failures = 0;
  int cyc = 0;
  int reqlen = 0;
  int rcnt = 0, ridx = 0;
  logic stray = 1'b0;

  logic        hit_t[256];
  int          lat_t[256];
  logic [31:0] vxa_t[256], vya_t[256], vxb_t[256], vyb_t[256];

  logic [N-1:0]    exp_coll;
  logic [N*32-1:0] exp_vx, exp_vy;
  logic            exp_ovr;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_tab();
    for (int i = 0; i < 256; i++) begin
      hit_t[i] = 1'b0; lat_t[i] = 1;
      vxa_t[i] = '0; vya_t[i] = '0; vxb_t[i] = '0; vyb_t[i] = '0;
    end
  endtask

  task automatic set_pair(input int a, input int b, input logic hit, input int lat,
                          input logic [31:0] xa, input logic [31:0] ya,
                          input logic [31:0] xb, input logic [31:0] yb);
    hit_t[a*16+b] = hit; lat_t[a*16+b] = lat;
    vxa_t[a*16+b] = xa; vya_t[a*16+b] = ya; vxb_t[a*16+b] = xb; vyb_t[a*16+b] = yb;
  endtask

  task automatic exp_pair(input int a, input int b, input int lat);
    pair_t p;
    p.a = a; p.b = b; p.lat = lat;
    pq.push_back(p);
  endtask

  task automatic exp_clear(input logic ovr);
    exp_coll = '0; exp_vx = '0; exp_vy = '0; exp_ovr = ovr;
  endtask

  task automatic setv(input int ball, input logic [31:0] x, input logic [31:0] y);
    exp_vx[ball*32 +: 32] = x;
    exp_vy[ball*32 +: 32] = y;
  endtask

  task automatic start_scan(input int off, input bit push_done);
    done_t d;
    int k;
    @(posedge clk); #1;
    sof = 1'b1;
    k = cyc + 1;
    if (push_done) begin
      d.per = k + off; d.coll = exp_coll; d.vx = exp_vx; d.vy = exp_vy; d.ovr = exp_ovr;
      dq.push_back(d);
    end
    @(posedge clk); #1;
    sof = 1'b0;
    chk("start_busy", 256'(busy), 256'(1));
    chk("start_coll_clear", 256'(collision), 256'(0));
    chk("start_vx_clear", 256'(nxt_vx), 256'(0));
    chk("start_vy_clear", 256'(nxt_vy), 256'(0));
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (dq.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    if (dq.size() != 0) begin
      checks++; failures++;
      $display("FAIL done_timeout: got no done within %0d cycles expected done pulse", bound);
      dq.delete();
    end
    chk("pairs_left", 256'(pq.size()), 256'(0));
    pq.delete();
    repeat (3) @(posedge clk);
    #1;
    chk("hold_coll", 256'(collision), 256'(exp_coll));
    chk("hold_vx", 256'(nxt_vx), 256'(exp_vx));
    chk("hold_busy", 256'(busy), 256'(0));
  endtask

  // Collision-unit model: acks on the lat-th request cycle, drives junk otherwise
  initial forever begin
    @(posedge clk); #1;
    if (calc_req) begin
      rcnt++;
      ridx = int'(calc_idx_a) * 16 + int'(calc_idx_b);
      if (rcnt == lat_t[ridx]) begin
        calc_ack = 1'b1; calc_hit = hit_t[ridx];
        vxa = vxa_t[ridx]; vya = vya_t[ridx]; vxb = vxb_t[ridx]; vyb = vyb_t[ridx];
      end else begin
        calc_ack = 1'b0; calc_hit = 1'b1;
        vxa = 32'hDEADBEEF; vya = 32'hDEADBEEF; vxb = 32'hDEADBEEF; vyb = 32'hDEADBEEF;
      end
    end else begin
      rcnt = 0;
      calc_ack = stray; calc_hit = stray;
      vxa = 32'h5A5A5A5A; vya = 32'h5A5A5A5A; vxb = 32'h5A5A5A5A; vyb = 32'h5A5A5A5A;
    end
  end

  initial forever begin
    @(negedge clk);
    if (reset) begin
      reqlen = 0;
    end else begin
      if (calc_req) begin
        reqlen++;
        if (pq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_req: got pair (%0d,%0d) expected no request", calc_idx_a, calc_idx_b);
        end else begin
          chk("req_idx_a", 256'(calc_idx_a), 256'(pq[0].a));
          chk("req_idx_b", 256'(calc_idx_b), 256'(pq[0].b));
          if (calc_ack) begin
            chk("req_len", 256'(reqlen), 256'(pq[0].lat));
            void'(pq.pop_front());
          end
        end
        if (calc_ack) reqlen = 0;
      end else begin
        reqlen = 0;
      end
      if (done) begin
        if (dq.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc + 1);
        end else begin
          md = dq.pop_front();
          chk("done_cycle", 256'(cyc + 1), 256'(md.per));
          chk("done_coll", 256'(collision), 256'(md.coll));
          chk("done_vx", 256'(nxt_vx), 256'(md.vx));
          chk("done_vy", 256'(nxt_vy), 256'(md.vy));
          chk("done_overrun", 256'(overrun), 256'(md.ovr));
          chk("done_busy", 256'(busy), 256'(0));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    clear_tab();
    exp_clear(1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 256'(calc_req), 256'(0));
    chk("rst_busy", 256'(busy), 256'(0));
    chk("rst_done", 256'(done), 256'(0));
    chk("rst_overrun", 256'(overrun), 256'(0));
    chk("rst_coll", 256'(collision), 256'(0));
    chk("rst_vx", 256'(nxt_vx), 256'(0));
    chk("rst_vy", 256'(nxt_vy), 256'(0));
    chk("rst_idx_a", 256'(calc_idx_a), 256'(0));
    chk("rst_idx_b", 256'(calc_idx_b), 256'(1));
    reset = 1'b0;
    repeat (2) @(posedge clk);

    // No hits: all six pairs requested, done at k+13
    act = 4'b1111;
    exp_pair(0, 1, 1); exp_pair(0, 2, 1); exp_pair(0, 3, 1);
    exp_pair(1, 2, 1); exp_pair(1, 3, 1); exp_pair(2, 3, 1);
    start_scan(13, 1'b1);
    wait_done(40);

    // Single hit on (0,1): balls 0 and 1 drop out, only (2,3) follows
    clear_tab();
    set_pair(0, 1, 1'b1, 1, 3, -2, -3, 2);
    exp_clear(1'b0);
    exp_coll = 4'b0011;
    setv(0, 3, -2);
    setv(1, -3, 2);
    exp_pair(0, 1, 1); exp_pair(2, 3, 1);
    start_scan(9, 1'b1);
    wait_done(40);

    // Pocketed balls 1 and 3: only (0,2); previous hits must be cleared
    clear_tab();
    act = 4'b0101;
    exp_clear(1'b0);
    exp_pair(0, 2, 1);
    start_scan(8, 1'b1);
    wait_done(40);

    // Slow ack on (1,2) with extreme values; (0,3) hit blocks (1,3) and (2,3)
    clear_tab();
    act = 4'b1111;
    set_pair(0, 3, 1'b1, 1, 5, 6, 7, 8);
    set_pair(1, 2, 1'b1, 5, -1, 32'h7FFFFFFF, 32'h80000000, -7);
    exp_clear(1'b0);
    exp_coll = 4'b1111;
    setv(0, 5, 6);
    setv(3, 7, 8);
    setv(1, -1, 32'h7FFFFFFF);
    setv(2, 32'h80000000, -7);
    exp_pair(0, 1, 1); exp_pair(0, 2, 1); exp_pair(0, 3, 1); exp_pair(1, 2, 5);
    start_scan(15, 1'b1);
    wait_done(60);

    // Overrun plus ack held high outside requests: scan must be unaffected
    clear_tab();
    stray = 1'b1;
    exp_clear(1'b1);
    exp_pair(0, 1, 1); exp_pair(0, 2, 1); exp_pair(0, 3, 1);
    exp_pair(1, 2, 1); exp_pair(1, 3, 1); exp_pair(2, 3, 1);
    start_scan(13, 1'b1);
    @(posedge clk); #1;
    sof = 1'b1;
    @(posedge clk); #1;
    sof = 1'b0;
    chk("overrun_set", 256'(overrun), 256'(1));
    wait_done(40);
    stray = 1'b0;

    // Overrun stays sticky across a later scan
    act = 4'b0101;
    exp_clear(1'b1);
    exp_pair(0, 2, 1);
    start_scan(8, 1'b1);
    wait_done(40);

    // Reset while (2,3) is waiting on a slow ack
    clear_tab();
    act = 4'b1111;
    set_pair(0, 1, 1'b1, 1, 1, 1, 1, 1);
    set_pair(2, 3, 1'b0, 10, 0, 0, 0, 0);
    exp_pair(0, 1, 1); exp_pair(2, 3, 10);
    start_scan(0, 1'b0);
    begin
      int n = 0;
      while (!(calc_req && calc_idx_a == 4'd2 && calc_idx_b == 4'd3) && n < 40) begin
        @(negedge clk);
        n++;
      end
      if (n >= 40) begin
        checks++; failures++;
        $display("FAIL reset_wait: got no request for (2,3) expected one within 40 cycles");
      end
    end
    chk("pre_reset_coll", 256'(collision), 256'(4'b0011));
    #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_req", 256'(calc_req), 256'(0));
    chk("mid_rst_busy", 256'(busy), 256'(0));
    chk("mid_rst_done", 256'(done), 256'(0));
    chk("mid_rst_coll", 256'(collision), 256'(0));
    chk("mid_rst_vx", 256'(nxt_vx), 256'(0));
    chk("mid_rst_vy", 256'(nxt_vy), 256'(0));
    chk("mid_rst_overrun", 256'(overrun), 256'(0));
    pq.delete();
    @(posedge clk); #1;
    reset = 1'b0;

    // Post-reset scan restarts from (0,1)
    clear_tab();
    exp_clear(1'b0);
    exp_pair(0, 1, 1); exp_pair(0, 2, 1); exp_pair(0, 3, 1);
    exp_pair(1, 2, 1); exp_pair(1, 3, 1); exp_pair(2, 3, 1);
    start_scan(13, 1'b1);
    wait_done(40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/collision_scheduler.md
# collision_scheduler

Per-frame ball-pair collision scheduler for the pool table. On each start of frame it walks every unordered pair of active balls and issues pairs one at a time to a single shared collision-math unit through a req/ack handshake. It latches the first hit per ball into per-ball velocity registers and presents the per-ball collision flag and next velocity to the ball-move modules. Lower pair index wins when one ball is involved in several hits.

## Interface
Parameters:
- NUM_BALLS, 4, number of balls; legal range 2..16.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse that starts a scan.
- ball_active  in  NUM_BALLS  bit i=1 means ball i is on the table; pocketed balls are skipped.
- calc_req  out  1  request to the shared collision unit.
- calc_idx_a  out  4  lower ball index of the current pair.
- calc_idx_b  out  4  higher ball index of the current pair.
- calc_ack  in  1  result valid; sampled only while calc_req=1.
- calc_hit  in  1  the pair collides; valid with calc_ack.
- calc_vx_a, calc_vy_a, calc_vx_b, calc_vy_b  in  32 each  signed next velocities for balls a and b; valid with calc_ack.
- collision  out  NUM_BALLS  per-ball hit flag for the last completed scan.
- nxt_vx, nxt_vy  out  NUM_BALLS×32  packed signed per-ball next velocities.
- busy  out  1  scan in progress.
- done  out  1  one-cycle pulse when a scan completes.
- overrun  out  1  sticky flag: startOfFrame arrived while busy.

## Operation
- FSM states are IDLE, NEXT, REQ and DONE.
- Pair order is lexicographic: (0,1), (0,2) … (0,N-1), (1,2) … (N-2,N-1), for P = N(N-1)/2 pairs.
- **IDLE:** on startOfFrame, clear collision, nxt_vx and nxt_vy to 0. Load pair (0,1) and go to NEXT.
- **NEXT:** a pair is eligible when both balls are active and neither has its collision flag set.
  - Eligible pair: go to REQ.
  - Ineligible pair: advance to the next pair and stay in NEXT, or go to DONE after the last pair.
  - One cycle per pair in either case.
- **REQ:**
  - calc_req=1, and calc_idx_a/b are held stable until the ack.
  - On the calc_ack cycle, if calc_hit=1:
    - set collision[a] and collision[b];
    - write calc_vx_a/vy_a into ball a and calc_vx_b/vy_b into ball b.
  - Then advance the pair as in NEXT; the target state is NEXT, or DONE after the last pair.
  - If calc_hit=0, nothing is written.
- **DONE:** done=1 for one cycle, then go to IDLE.
- A ball hit by an earlier pair is not requested again in the same scan (first-hit priority).
- ball_active is sampled live in NEXT; the producer holds it stable during a scan.
- Velocities pass through unmodified as 32-bit two's complement.
- Outputs hold their values from DONE until the next accepted startOfFrame.

## Timing
- Reset values: all outputs 0, state IDLE, pair (0,1). Reset asserted mid-scan aborts at once, and the next scan restarts from pair (0,1).
- startOfFrame sampled on edge k in IDLE:
  - outputs are cleared and busy=1 from cycle k+1;
  - the first NEXT is in cycle k+1.
- Request timing:
  - calc_req rises in the cycle after the NEXT cycle.
  - calc_ack may arrive in the same cycle as calc_req (minimum 1 cycle).
  - calc_req is 0 in the cycle after the ack.
- Minimum scan length, with all pairs requested and immediate ack: DONE in cycle k+1+2P. Each skipped pair saves one cycle.
- busy=1 in NEXT and REQ; busy=0 in IDLE and DONE.
- startOfFrame in any non-IDLE state is ignored and sets overrun. overrun is cleared only by reset.
- calc_ack while calc_req=0 is ignored.
- calc_ack held high across consecutive requests is legal; each REQ cycle with ack=1 consumes one result.

## Test plan
- **No hits:** NUM_BALLS=4, all active, ack same cycle, calc_hit=0 → calc_req pulses 6 times for pairs (0,1) through (2,3); done at k+13; collision=0000; all velocities 0.
- **Single hit:** pair (0,1) hits with vx_a=3, vy_a=-2, vx_b=-3, vy_b=2 → collision=0011; ball0=(3,-2), ball1=(-3,2); pairs (0,2),(0,3),(1,2),(1,3) are never requested; (2,3) is requested; done at k+9.
- **Pocketed balls:** ball_active=0101 with no hits → only pair (0,2) is requested; done at k+8.
- **Slow ack:** ack arrives 5 cycles after req on pair (1,2) → calc_idx_a=1 and calc_idx_b=2 stable throughout, req high for exactly 5 cycles; hit values are latched only on the ack cycle.
- **Overrun:** second startOfFrame while busy → scan unaffected, overrun=1 and remains 1 across later scans until reset.
- **Mid-scan reset:** reset asserted during REQ → calc_req, busy, done, collision and all velocities are 0 immediately; the next startOfFrame scans starting from pair (0,1).
